// File: rtl/bus_master_ctrl.sv
// Serial bus master: accepts a parallel command, sends an 18-bit address frame on
// control, then shifts write words out on wD or collects read words from rD.
module bus_master_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 2000,
  parameter int SLAVES     = 3,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 64,
  localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  localparam int S_ID_WIDTH = $clog2(SLAVES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [S_ID_WIDTH-1:0] cmd_slave_id,
  input  logic                  cmd_write,
  input  logic                  cmd_burst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  output logic                  last,
  input  logic                  rD,
  input  logic                  ready
);

  localparam int FRAME_LEN = 5 + S_ID_WIDTH + ADDR_WIDTH;
  localparam int CNT_MAX   = (FRAME_LEN > DATA_WIDTH) ? FRAME_LEN : DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(CNT_MAX);
  localparam int TO_WIDTH  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME,
    S_WR_LOAD,
    S_WR_SHIFT,
    S_RD_SHIFT,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [FRAME_LEN-1:0]   frame_sh;
  logic [DATA_WIDTH-1:0]  data_sh;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [LEN_WIDTH-1:0]   word_cnt;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   write_q;
  logic [TO_WIDTH-1:0]    to_cnt;

  logic cmd_illegal;
  logic frame_end;
  logic word_end;
  logic final_word;
  logic to_expired;

  // A zero id, an id beyond the last slave, or an empty burst never reaches the bus.
  assign cmd_illegal = (cmd_slave_id == '0) || (int'(cmd_slave_id) > SLAVES) ||
                       (cmd_burst && (cmd_len == '0));
  assign frame_end   = (cnt == CNT_WIDTH'(FRAME_LEN - 1));
  assign word_end    = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign final_word  = (word_cnt == (len_q - LEN_WIDTH'(1)));
  assign to_expired  = (to_cnt == TO_WIDTH'(TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    control    = 1'b0;
    wD         = 1'b0;
    valid      = 1'b0;
    last       = 1'b0;
    wr_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) next_state = cmd_illegal ? S_FAIL : S_FRAME;
      end
      S_FRAME: begin
        control = frame_sh[FRAME_LEN-1];
        if (frame_end) next_state = write_q ? S_WR_LOAD : S_RD_SHIFT;
      end
      S_WR_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) next_state = S_WR_SHIFT;
      end
      S_WR_SHIFT: begin
        wD    = data_sh[DATA_WIDTH-1];
        valid = 1'b1;
        last  = final_word;
        if (word_end) next_state = final_word ? S_FINISH : S_WR_LOAD;
      end
      S_RD_SHIFT: begin
        last = final_word;
        if (ready) begin
          if (word_end && final_word) next_state = S_FINISH;
        end else if (to_expired) begin
          next_state = S_FAIL;
        end
      end
      S_FINISH: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      S_FAIL: begin
        error      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      frame_sh <= '0;
      data_sh  <= '0;
      cnt      <= '0;
      word_cnt <= '0;
      len_q    <= '0;
      write_q  <= 1'b0;
      to_cnt   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= next_state;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            frame_sh <= {3'b111, cmd_slave_id, cmd_write, cmd_burst, cmd_addr};
            write_q  <= cmd_write;
            len_q    <= cmd_burst ? cmd_len : LEN_WIDTH'(1);
            cnt      <= '0;
            word_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        S_FRAME: begin
          frame_sh <= frame_sh << 1;
          cnt      <= frame_end ? '0 : cnt + 1'b1;
        end
        S_WR_LOAD: begin
          if (wr_valid) begin
            data_sh <= wr_data;
            cnt     <= '0;
          end
        end
        S_WR_SHIFT: begin
          data_sh <= data_sh << 1;
          if (word_end) begin
            cnt <= '0;
            if (!final_word) word_cnt <= word_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_SHIFT: begin
          if (ready) begin
            to_cnt  <= '0;
            data_sh <= {data_sh[DATA_WIDTH-2:0], rD};
            if (word_end) begin
              cnt      <= '0;
              rd_data  <= {data_sh[DATA_WIDTH-2:0], rD};
              rd_valid <= 1'b1;
              if (!final_word) word_cnt <= word_cnt + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Bench for bus_master_ctrl: each transaction is expanded into a per-cycle timeline of
// stimulus and expected outputs, then replayed and compared cycle by cycle.
module tb_bus_master_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 11;
  localparam int IW   = 2;
  localparam int LW   = 8;
  localparam int TMO  = 64;
  localparam int NSLV = 3;

  // Bit positions inside the packed vector of single-bit outputs.
  localparam int B_CRDY = 9, B_BUSY = 8, B_CTRL = 7, B_VAL = 6, B_WD = 5;
  localparam int B_LAST = 4, B_WRDY = 3, B_RDV = 2, B_DONE = 1, B_ERR = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_slave_id;
  logic          cmd_write;
  logic          cmd_burst;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy, done, error;
  logic          control, wD, valid, last;
  logic          rD, ready;

  always #5 clk = ~clk;

  bus_master_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave_id(cmd_slave_id),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .error(error),
    .control(control), .wD(wD), .valid(valid), .last(last),
    .rD(rD), .ready(ready)
  );

  typedef struct {
    logic          rst;
    logic          cmd_valid;
    logic [IW-1:0] id;
    logic          wr;
    logic          burst;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rD;
    logic          ready;
    logic [9:0]    exp;
    logic          chk_rd;
    logic [DW-1:0] exp_rd;
  } step_t;

  step_t         q[$];
  logic [DW-1:0] words[$];
  int            gaps[$];
  int            stalls[$];
  logic          pend = 1'b0;
  logic [DW-1:0] pend_val = '0;
  int            tests = 0;
  int            failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A cycle with no particular expectations: inputs the controller must ignore are random.
  function automatic step_t blank(input bit act);
    step_t s;
    s.rst       = 1'b0;
    s.cmd_valid = act ? 1'($urandom) : 1'b0;
    s.id        = IW'($urandom);
    s.wr        = 1'($urandom);
    s.burst     = 1'($urandom);
    s.addr      = AW'($urandom);
    s.len       = LW'($urandom);
    s.wr_valid  = 1'($urandom);
    s.wr_data   = $urandom;
    s.rD        = 1'($urandom);
    s.ready     = 1'($urandom);
    s.exp       = '0;
    if (act) s.exp[B_BUSY] = 1'b1;
    else     s.exp[B_CRDY] = 1'b1;
    s.chk_rd    = 1'b0;
    s.exp_rd    = '0;
    return s;
  endfunction

  // A completed read word is announced on whichever cycle follows its last bit.
  function automatic void push(input step_t st);
    step_t s;
    s = st;
    if (pend) begin
      s.exp[B_RDV] = 1'b1;
      s.chk_rd     = 1'b1;
      s.exp_rd     = pend_val;
      pend         = 1'b0;
    end
    q.push_back(s);
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push(blank(1'b0));
  endfunction

  // Expands one command into its expected cycle timeline from words/gaps/stalls.
  function automatic void add_txn(input logic [IW-1:0] id, input bit wr, input bit burst,
                                  input logic [AW-1:0] addr, input logic [LW-1:0] len);
    step_t       s;
    logic [17:0] frame;
    int          n;
    int          k;
    bit          illegal;
    bit          fin;
    illegal = (id == 0) || (int'(id) > NSLV) || (burst && len == 0);
    n = burst ? int'(len) : 1;
    s = blank(1'b0);
    s.cmd_valid = 1'b1; s.id = id; s.wr = wr; s.burst = burst; s.addr = addr; s.len = len;
    push(s);
    if (illegal) begin
      s = blank(1'b1); s.exp[B_ERR] = 1'b1; push(s);
      return;
    end
    frame = {3'b111, id, wr, burst, addr};
    for (int i = 17; i >= 0; i--) begin
      s = blank(1'b1); s.exp[B_CTRL] = frame[i]; push(s);
    end
    k = 0;
    for (int w = 0; w < n; w++) begin
      fin = (w == n - 1);
      if (wr) begin
        for (int g = 0; g < gaps[w]; g++) begin
          s = blank(1'b1);
          s.exp[B_WRDY] = 1'b1;
          s.wr_valid = (g == gaps[w] - 1);
          if (s.wr_valid) s.wr_data = words[w];
          push(s);
        end
        for (int b = DW - 1; b >= 0; b--) begin
          s = blank(1'b1);
          s.exp[B_VAL] = 1'b1; s.exp[B_WD] = words[w][b]; s.exp[B_LAST] = fin;
          push(s);
        end
      end else begin
        for (int b = DW - 1; b >= 0; b--) begin
          for (int z = 0; z < stalls[k]; z++) begin
            s = blank(1'b1); s.ready = 1'b0; s.exp[B_LAST] = fin; push(s);
            if (z == TMO - 1) begin
              s = blank(1'b1); s.exp[B_ERR] = 1'b1; push(s);
              return;
            end
          end
          k++;
          s = blank(1'b1); s.ready = 1'b1; s.rD = words[w][b]; s.exp[B_LAST] = fin;
          push(s);
        end
        pend = 1'b1;
        pend_val = words[w];
      end
    end
    s = blank(1'b1); s.exp[B_DONE] = 1'b1; push(s);
  endfunction

  function automatic void clear_lists();
    words.delete(); gaps.delete(); stalls.delete();
  endfunction

  function automatic void fill_random(input int n, input int max_gap, input int max_stall);
    for (int i = 0; i < n; i++) begin
      words.push_back($urandom);
      gaps.push_back($urandom_range(1, max_gap));
    end
    for (int i = 0; i < n * DW; i++) stalls.push_back($urandom_range(0, max_stall));
  endfunction

  task automatic run(input string name);
    step_t s;
    for (int i = 0; i < q.size(); i++) begin
      s = q[i];
      @(negedge clk);
      rst = s.rst; cmd_valid = s.cmd_valid; cmd_slave_id = s.id; cmd_write = s.wr;
      cmd_burst = s.burst; cmd_addr = s.addr; cmd_len = s.len;
      wr_valid = s.wr_valid; wr_data = s.wr_data; rD = s.rD; ready = s.ready;
      check($sformatf("%s#%0d outputs", name, i),
            64'({cmd_ready, busy, control, valid, wD, last, wr_ready, rd_valid, done, error}),
            64'(s.exp));
      if (s.chk_rd) check($sformatf("%s#%0d rd_data", name, i), 64'(rd_data), 64'(s.exp_rd));
    end
    q.delete();
  endtask

  initial begin
    step_t s;
    int    n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_slave_id = '0; cmd_write = 1'b0; cmd_burst = 1'b0;
    cmd_addr = '0; cmd_len = '0; wr_valid = 1'b0; wr_data = '0; rD = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs",
          64'({cmd_ready, busy, control, valid, wD, last, wr_ready, rd_valid, done, error}),
          64'(10'b10_0000_0000));
    check("reset rd_data", 64'(rd_data), 64'(0));

    // Single write, slave 1, addr 0x005; cmd_len is ignored without burst.
    clear_lists(); words.push_back(32'hA5A5_0F0F); gaps.push_back(1);
    add_txn(2'd1, 1'b1, 1'b0, 11'h005, 8'd0); add_idle(2);
    run("single_write");

    // Burst read of 1, 2, 3 with the slave always ready.
    clear_lists();
    for (int i = 1; i <= 3; i++) begin words.push_back(DW'(i)); gaps.push_back(1); end
    for (int i = 0; i < 3 * DW; i++) stalls.push_back(0);
    add_txn(2'd2, 1'b0, 1'b1, 11'h010, 8'd3); add_idle(2);
    run("burst_read");

    // Burst write with five wait cycles before the second word.
    clear_lists(); words.push_back($urandom); words.push_back($urandom);
    gaps.push_back(1); gaps.push_back(5);
    add_txn(2'd3, 1'b1, 1'b1, 11'h7FF, 8'd2); add_idle(2);
    run("burst_write_gap");

    // Illegal commands back to back, then a zero-ready read that must time out.
    clear_lists(); fill_random(1, 1, 0); stalls[0] = TMO;
    add_txn(2'd0, 1'b1, 1'b0, 11'h123, 8'd4);
    add_txn(2'd3, 1'b0, 1'b1, 11'h456, 8'd0);
    add_txn(2'd1, 1'b0, 1'b0, 11'h020, 8'd9); add_idle(3);
    run("illegal_and_timeout");

    // Reset on the tenth frame bit of a write: no done/error, registers cleared.
    clear_lists(); fill_random(1, 2, 0);
    add_txn(2'd1, 1'b1, 1'b0, 11'h0AA, 8'd0);
    while (q.size() > 11) void'(q.pop_back());
    s = q[10]; s.rst = 1'b1; q[10] = s;
    s = blank(1'b0); s.chk_rd = 1'b1; s.exp_rd = '0; push(s);
    add_idle(3);
    run("reset_mid_frame");

    // Longest burst: 255 read words, no counter wrap.
    clear_lists(); fill_random(255, 1, 0);
    for (int i = 0; i < 255 * DW; i += 97) stalls[i] = 2;
    add_txn(2'd3, 1'b0, 1'b1, 11'h3C0, 8'd255); add_idle(2);
    run("len_255_read");

    // Randomized mix, including illegal ids/lengths and occasional long stalls.
    for (int t = 0; t < 30; t++) begin
      clear_lists();
      n = $urandom_range(1, 4);
      fill_random(n, 4, ($urandom_range(0, 3) == 0) ? 3 : 0);
      if ($urandom_range(0, 5) == 0) stalls[$urandom_range(0, n * DW - 1)] = $urandom_range(50, 70);
      add_txn(IW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), AW'($urandom),
              LW'($urandom_range(0, n)));
      add_idle($urandom_range(0, 2));
    end
    add_idle(2);
    run("random_mix");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
